button_event_ctrl: RTL and testbench
====================================

// Module: button_event_ctrl
// PURPOSE
//  Debounces NUM_BTN raw buttons and sequences them into user events: press, release,
//  long-press and auto-repeat. One shared prescaler generates a timebase tick; each
//  channel runs a small FSM whose counters advance only on that tick. Sits between the
//  board button pins and the application FSMs (menus, games, counters).
// PARAMETERS
//  NUM_BTN        4      number of button channels
//  CLKS_PER_TICK  12000  CLK cycles per timebase tick (1 ms at 12 MHz)
//  DEBOUNCE_TICKS 10     consecutive ticks an input must hold a new level to be accepted
//  LONG_TICKS     1000   ticks held before o_Long fires
//  REPEAT_TICKS   200    ticks between o_Repeat pulses after o_Long
// PORTS
//  CLK       in   1        system clock
//  i_RST_N   in   1        asynchronous, active-low reset
//  i_BTN     in   NUM_BTN  raw button inputs, asynchronous, 1 = pressed
//  i_Enable  in   1        0 freezes prescaler and all channels
//  o_BTN     out  NUM_BTN  debounced level per channel
//  o_Press   out  NUM_BTN  1-cycle pulse when a press is accepted
//  o_Release out  NUM_BTN  1-cycle pulse when a release is accepted
//  o_Long    out  NUM_BTN  1-cycle pulse, once per hold, LONG_TICKS after press accepted
//  o_Repeat  out  NUM_BTN  1-cycle pulse every REPEAT_TICKS after o_Long while held
//  o_Tick    out  1        1-cycle timebase tick (for other blocks)
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, sync FFs 0, prescaler 0, FSMs UP.
//  - Each i_BTN bit passes a 2-FF synchroniser; FSMs see only the synchronised bit s.
//  - Prescaler counts 0..CLKS_PER_TICK-1, wraps; o_Tick=1 in the cycle count==max.
//    i_Enable=0: prescaler holds, o_Tick=0, FSM state/counters hold, no event pulses.
//  - Channel FSM, states UP, CHK_DN, DOWN, CHK_UP; debounce count dc, hold count hc:
//    UP:     s=1 -> CHK_DN, dc=0.
//    CHK_DN: s=0 -> UP (no event). tick & dc==DEBOUNCE_TICKS-1 -> DOWN, hc=0,
//            long_done=0, o_BTN<=1, o_Press pulse; else tick -> dc++.
//    DOWN:   s=0 -> CHK_UP, dc=0. tick -> hc++; tick & !long_done & hc==LONG_TICKS-1
//            -> o_Long pulse, long_done=1, hc=0; tick & long_done & hc==REPEAT_TICKS-1
//            -> o_Repeat pulse, hc=0.
//    CHK_UP: s=1 -> DOWN, hc/long_done kept (bounce is not a new press). tick &
//            dc==DEBOUNCE_TICKS-1 -> UP, o_BTN<=0, o_Release pulse; else tick -> dc++.
//  - s change and tick in same cycle: the s transition wins; dc is cleared, not advanced.
//  - Acceptance latency: 2 sync cycles + DEBOUNCE_TICKS ticks (first tick may be partial).
//  - hc does not tick in CHK_UP; all event outputs registered; o_Press coincides with
//    first cycle o_BTN=1, o_Release with first cycle o_BTN=0.
//  - Counter widths $clog2(param+1); params must be >=1; DEBOUNCE_TICKS=1 accepts on first tick.
//  - Channels are independent; simultaneous events on several bits are all reported.
// STRUCTURE
//  - Include file button_event_defs.vh: FSM state localparams (UP=0,CHK_DN=1,DOWN=2,CHK_UP=3).
//  - Top: synchronisers, shared prescaler, generate loop of channels.
//  - Sub-module button_channel: one FSM + dc/hc counters, takes s, tick, enable.
// TESTING (CLKS_PER_TICK=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=4, NUM_BTN=4)
//  1 Reset: drive i_RST_N=0 mid-run -> all outputs 0 immediately; o_Tick every 4 cycles after.
//  2 Clean press of bit0 held 20 ticks -> one o_Press[0], o_BTN[0]=1 within 2+12 cycles;
//    o_Long[0] 8 ticks after press; o_Repeat[0] at +4 and +8 ticks thereafter.
//  3 Bounce: bit1 toggles every 5 cycles for 40 cycles, then low -> no o_Press[1], o_BTN[1]=0.
//  4 Release glitch: bit0 held, 1-tick low pulse -> no o_Release, hc continues, o_Long on time.
//  5 i_Enable=0 for 30 cycles during CHK_DN -> no tick/events; resumes with dc retained.
//  6 Bits 2,3 pressed same cycle -> o_Press=4'b1100 in one cycle; release same -> o_Release=4'b1100.

Source files
------------

// File: rtl/button_event_ctrl_pkg.sv
// Shared types and helpers for the button event controller.
// Channel FSM state encoding and counter width sizing.
package button_event_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_CHK_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_CHK_UP = 2'd3
    } btn_state_t;

    // Width able to hold the value v; never below one bit.
    function automatic int cnt_w(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/button_event_ctrl_channel.sv
// One button channel: debounce FSM plus hold counter producing press, release,
// long-press and auto-repeat pulses. Counters advance only on the shared tick.
module button_event_ctrl_channel
    import button_event_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic s,
    input  logic tick,
    input  logic enable,
    output logic lvl,
    output logic press_pls,
    output logic release_pls,
    output logic long_pls,
    output logic repeat_pls
);

    localparam int HC_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int DC_W   = cnt_w(DEBOUNCE_TICKS);
    localparam int HC_W   = cnt_w(HC_MAX);

    localparam logic [DC_W-1:0] DC_LAST  = DC_W'(DEBOUNCE_TICKS - 1);
    localparam logic [HC_W-1:0] HC_LONG  = HC_W'(LONG_TICKS - 1);
    localparam logic [HC_W-1:0] HC_RPT   = HC_W'(REPEAT_TICKS - 1);

    btn_state_t      state, state_nx;
    logic [DC_W-1:0] dc, dc_nx;
    logic [HC_W-1:0] hc, hc_nx;
    logic            long_done, long_done_nx;
    logic            lvl_nx, press_nx, release_nx, long_nx, repeat_nx;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_UP;
            dc          <= '0;
            hc          <= '0;
            long_done   <= 1'b0;
            lvl         <= 1'b0;
            press_pls   <= 1'b0;
            release_pls <= 1'b0;
            long_pls    <= 1'b0;
            repeat_pls  <= 1'b0;
        end else begin
            state       <= state_nx;
            dc          <= dc_nx;
            hc          <= hc_nx;
            long_done   <= long_done_nx;
            lvl         <= lvl_nx;
            press_pls   <= press_nx;
            release_pls <= release_nx;
            long_pls    <= long_nx;
            repeat_pls  <= repeat_nx;
        end
    end

    // A level change on s always takes priority over a coincident tick.
    always_comb begin
        state_nx     = state;
        dc_nx        = dc;
        hc_nx        = hc;
        long_done_nx = long_done;
        lvl_nx       = lvl;
        press_nx     = 1'b0;
        release_nx   = 1'b0;
        long_nx      = 1'b0;
        repeat_nx    = 1'b0;
        if (enable) begin
            case (state)
                ST_UP: begin
                    if (s) begin
                        state_nx = ST_CHK_DN;
                        dc_nx    = '0;
                    end
                end
                ST_CHK_DN: begin
                    if (!s) begin
                        state_nx = ST_UP;
                    end else if (tick) begin
                        if (dc == DC_LAST) begin
                            state_nx     = ST_DOWN;
                            hc_nx        = '0;
                            long_done_nx = 1'b0;
                            lvl_nx       = 1'b1;
                            press_nx     = 1'b1;
                        end else begin
                            dc_nx = dc + 1'b1;
                        end
                    end
                end
                ST_DOWN: begin
                    if (!s) begin
                        state_nx = ST_CHK_UP;
                        dc_nx    = '0;
                    end else if (tick) begin
                        if (!long_done && hc == HC_LONG) begin
                            long_nx      = 1'b1;
                            long_done_nx = 1'b1;
                            hc_nx        = '0;
                        end else if (long_done && hc == HC_RPT) begin
                            repeat_nx = 1'b1;
                            hc_nx     = '0;
                        end else begin
                            hc_nx = hc + 1'b1;
                        end
                    end
                end
                ST_CHK_UP: begin
                    // Returning high here is a bounce: hold count and long state survive.
                    if (s) begin
                        state_nx = ST_DOWN;
                    end else if (tick) begin
                        if (dc == DC_LAST) begin
                            state_nx   = ST_UP;
                            lvl_nx     = 1'b0;
                            release_nx = 1'b1;
                        end else begin
                            dc_nx = dc + 1'b1;
                        end
                    end
                end
                default: state_nx = ST_UP;
            endcase
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller top: reset and input synchronisers, shared timebase
// prescaler, and one debounce/event channel per button.
module button_event_ctrl
    import button_event_ctrl_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int CLKS_PER_TICK  = 12000,
    parameter int DEBOUNCE_TICKS = 10,
    parameter int LONG_TICKS     = 1000,
    parameter int REPEAT_TICKS   = 200
) (
    input  logic               CLK,
    input  logic               i_RST_N,
    input  logic [NUM_BTN-1:0] i_BTN,
    input  logic               i_Enable,
    output logic [NUM_BTN-1:0] o_BTN,
    output logic [NUM_BTN-1:0] o_Press,
    output logic [NUM_BTN-1:0] o_Release,
    output logic [NUM_BTN-1:0] o_Long,
    output logic [NUM_BTN-1:0] o_Repeat,
    output logic               o_Tick
);

    localparam int              PS_W    = cnt_w(CLKS_PER_TICK);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_TICK - 1);

    logic               rst_sync_p0, rst_sync_p1;
    logic               rst_n;
    logic [NUM_BTN-1:0] btn_sync_p0, btn_sync_p1;
    logic [PS_W-1:0]    presc;
    logic               tick;

    // Reset asserts asynchronously, releases two clocks after i_RST_N rises.
    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            rst_sync_p0 <= 1'b0;
            rst_sync_p1 <= 1'b0;
        end else begin
            rst_sync_p0 <= 1'b1;
            rst_sync_p1 <= rst_sync_p0;
        end
    end

    assign rst_n = rst_sync_p1;

    // Stage p0/p1: two-flop synchroniser on the raw button pins.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_p0 <= '0;
            btn_sync_p1 <= '0;
        end else begin
            btn_sync_p0 <= i_BTN;
            btn_sync_p1 <= btn_sync_p0;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (i_Enable) begin
            presc <= (presc == PS_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign tick   = i_Enable && (presc == PS_LAST);
    assign o_Tick = tick;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        button_event_ctrl_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .LONG_TICKS     (LONG_TICKS),
            .REPEAT_TICKS   (REPEAT_TICKS)
        ) u_ch (
            .CLK         (CLK),
            .rst_n       (rst_n),
            .s           (btn_sync_p1[g]),
            .tick        (tick),
            .enable      (i_Enable),
            .lvl         (o_BTN[g]),
            .press_pls   (o_Press[g]),
            .release_pls (o_Release[g]),
            .long_pls    (o_Long[g]),
            .repeat_pls  (o_Repeat[g])
        );
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: expected events are queued when stimulus
// is driven and matched (type, mask, cycle window) as the DUT pulses them.
module tb_button_event_ctrl;

    localparam int NB = 4;

    logic          CLK = 1'b0;
    logic          i_RST_N = 1'b0;
    logic          i_Enable = 1'b0;
    logic [NB-1:0] i_BTN = '0;
    logic [NB-1:0] o_BTN, o_Press, o_Release, o_Long, o_Repeat;
    logic          o_Tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         typ;   // 0 press, 1 release, 2 long, 3 repeat
        logic [3:0] mask;
        bit         rel;   // window relative to previous matched event
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb[$];
    int   last_cyc = 0;
    bit   mon_en   = 1'b0;

    button_event_ctrl #(
        .NUM_BTN        (NB),
        .CLKS_PER_TICK  (4),
        .DEBOUNCE_TICKS (3),
        .LONG_TICKS     (8),
        .REPEAT_TICKS   (4)
    ) dut (
        .CLK       (CLK),
        .i_RST_N   (i_RST_N),
        .i_BTN     (i_BTN),
        .i_Enable  (i_Enable),
        .o_BTN     (o_BTN),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Long    (o_Long),
        .o_Repeat  (o_Repeat),
        .o_Tick    (o_Tick)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_win(input string tag, input int c, input int lo, input int hi);
        checks++;
        assert (c >= lo && c <= hi) else begin
            failures++;
            $error("FAIL %s observed cycle=%0d expected=%0d..%0d", tag, c, lo, hi);
        end
    endtask

    task automatic push_ev(input int typ, input logic [3:0] mask, input bit rel,
                           input int lo, input int hi);
        exp_t e;
        e.typ  = typ;
        e.mask = mask;
        e.rel  = rel;
        e.lo   = lo;
        e.hi   = hi;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] ev_vec(input int t);
        case (t)
            0:       return o_Press;
            1:       return o_Release;
            2:       return o_Long;
            default: return o_Repeat;
        endcase
    endfunction

    // Event monitor: every pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        logic [3:0] v;
        exp_t       e;
        int         lo, hi;
        if (mon_en) begin
            for (int t = 0; t < 4; t++) begin
                v = ev_vec(t);
                if (v != 4'b0000) begin
                    checki("sb_has_entry", sb.size(), (sb.size() == 0) ? 1 : sb.size());
                    if (sb.size() != 0) begin
                        e  = sb.pop_front();
                        lo = e.rel ? last_cyc + e.lo : e.lo;
                        hi = e.rel ? last_cyc + e.hi : e.hi;
                        checki("ev_type", t, e.typ);
                        check4("ev_mask", v, e.mask);
                        check_win("ev_cycle", cyc, lo, hi);
                        if (t == 0) check4("press_lvl", o_BTN & v, v);
                        if (t == 1) check4("release_lvl", o_BTN & v, 4'b0000);
                        last_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, k, bad;

        // Reset state
        i_RST_N  = 1'b0;
        i_Enable = 1'b1;
        i_BTN    = '0;
        repeat (3) @(negedge CLK);
        check4("rst_btn",     o_BTN,     4'b0000);
        check4("rst_press",   o_Press,   4'b0000);
        check4("rst_release", o_Release, 4'b0000);
        check4("rst_long",    o_Long,    4'b0000);
        check4("rst_repeat",  o_Repeat,  4'b0000);
        checki("rst_tick",    int'(o_Tick), 0);
        i_RST_N = 1'b1;
        mon_en  = 1'b1;
        repeat (6) @(negedge CLK);

        // Clean press of bit0 held 20 ticks: press, long, two repeats, release
        n = cyc;
        i_BTN[0] = 1'b1;
        push_ev(0, 4'b0001, 1'b0, n + 12, n + 15);
        push_ev(2, 4'b0001, 1'b1, 32, 32);
        push_ev(3, 4'b0001, 1'b1, 16, 16);
        push_ev(3, 4'b0001, 1'b1, 16, 16);
        repeat (80) @(negedge CLK);
        check4("t2_held_btn", o_BTN, 4'b0001);
        n = cyc;
        i_BTN[0] = 1'b0;
        push_ev(1, 4'b0001, 1'b0, n + 12, n + 15);
        repeat (24) @(negedge CLK);
        check4("t2_released_btn", o_BTN, 4'b0000);
        checki("t2_sb_empty", sb.size(), 0);

        // Bounce on bit1: toggles every 5 cycles, never accepted
        for (int i = 0; i < 8; i++) begin
            i_BTN[1] = ~i_BTN[1];
            repeat (5) @(negedge CLK);
        end
        i_BTN[1] = 1'b0;
        repeat (20) @(negedge CLK);
        check4("t3_bounce_btn", o_BTN, 4'b0000);
        checki("t3_sb_empty", sb.size(), 0);

        // Release glitch on bit0: one tick lost from hold count, no release
        n = cyc;
        i_BTN[0] = 1'b1;
        push_ev(0, 4'b0001, 1'b0, n + 12, n + 15);
        push_ev(2, 4'b0001, 1'b1, 36, 36);
        k = 0;
        while (o_Press[0] !== 1'b1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        checki("t4_press_seen", int'(o_Press[0]), 1);
        repeat (8) @(negedge CLK);
        i_BTN[0] = 1'b0;
        repeat (4) @(negedge CLK);
        i_BTN[0] = 1'b1;
        repeat (10) @(negedge CLK);
        check4("t4_glitch_btn", o_BTN, 4'b0001);
        repeat (18) @(negedge CLK);
        m = cyc;
        i_BTN[0] = 1'b0;
        push_ev(1, 4'b0001, 1'b0, m + 12, m + 15);
        repeat (24) @(negedge CLK);
        checki("t4_sb_empty", sb.size(), 0);

        // Enable low for 30 cycles while bit0 is in debounce
        n = cyc;
        i_BTN[0] = 1'b1;
        push_ev(0, 4'b0001, 1'b0, n + 42, n + 45);
        repeat (4) @(negedge CLK);
        i_Enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (o_Tick !== 1'b0 || o_Press !== 4'b0000) bad++;
        end
        checki("t5_frozen", bad, 0);
        check4("t5_frozen_btn", o_BTN, 4'b0000);
        i_Enable = 1'b1;
        repeat (14) @(negedge CLK);
        check4("t5_resumed_btn", o_BTN, 4'b0001);
        m = cyc;
        i_BTN[0] = 1'b0;
        push_ev(1, 4'b0001, 1'b0, m + 12, m + 15);
        repeat (20) @(negedge CLK);
        checki("t5_sb_empty", sb.size(), 0);

        // Bits 2 and 3 pressed and released together
        n = cyc;
        i_BTN = 4'b1100;
        push_ev(0, 4'b1100, 1'b0, n + 12, n + 15);
        repeat (20) @(negedge CLK);
        check4("t6_both_btn", o_BTN, 4'b1100);
        m = cyc;
        i_BTN = 4'b0000;
        push_ev(1, 4'b1100, 1'b0, m + 12, m + 15);
        repeat (20) @(negedge CLK);
        check4("t6_both_released", o_BTN, 4'b0000);

        // Reset mid-run with bit0 held, then tick cadence after release
        n = cyc;
        i_BTN[0] = 1'b1;
        push_ev(0, 4'b0001, 1'b0, n + 12, n + 15);
        repeat (18) @(negedge CLK);
        check4("t1_pre_rst_btn", o_BTN, 4'b0001);
        #2;
        i_RST_N = 1'b0;
        i_BTN   = '0;
        #1;
        check4("t1_rst_btn", o_BTN, 4'b0000);
        check4("t1_rst_events", o_Press | o_Release | o_Long | o_Repeat, 4'b0000);
        checki("t1_rst_tick", int'(o_Tick), 0);
        repeat (3) @(negedge CLK);
        i_RST_N = 1'b1;
        n = cyc;
        k = 0;
        while (o_Tick !== 1'b1 && k < 12) begin
            @(negedge CLK);
            k++;
        end
        checki("t1_first_tick", cyc - n, 5);
        for (int p = 0; p < 3; p++) begin
            k = 0;
            do begin
                @(negedge CLK);
                k++;
            end while (o_Tick !== 1'b1 && k < 10);
            checki("t1_tick_period", k, 4);
        end
        repeat (20) @(negedge CLK);
        check4("t1_post_rst_btn", o_BTN, 4'b0000);
        checki("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
